// File: rtl/instr_fetch_mem.sv
// Byte-addressed instruction memory for the IF stage: valid/ready fetch with fixed read latency,
// stall hold, flush, alignment/range faults and a byte-wide run-time load port.
module instr_fetch_mem #(
    parameter int unsigned DEPTH        = 512,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned INSTR_BYTES  = 4,
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          BIG_ENDIAN   = 1'b1,
    parameter string       INIT_FILE    = "program.hex"
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     fetch_ready,
    output logic                     instr_valid,
    output logic [8*INSTR_BYTES-1:0] instruction,
    output logic [1:0]               fault,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     load_en,
    input  logic [ADDR_W-1:0]        load_addr,
    input  logic [7:0]               load_data
);

    localparam int unsigned IdxW    = $clog2(DEPTH);
    localparam int unsigned OffW    = $clog2(INSTR_BYTES);
    localparam int unsigned DataW   = 8 * INSTR_BYTES;
    localparam logic [ADDR_W-1:0] DepthA  = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LastA   = ADDR_W'(DEPTH - INSTR_BYTES);
    localparam logic [2:0]        LastCnt = 3'(READ_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [DataW-1:0]   instr_q, instr_d;
    logic [1:0]         fault_q, fault_d;
    logic [7:0]         mem [DEPTH];
    logic               accept;
    logic               misaligned;
    logic               out_of_range;
    logic [IdxW-1:0]    base;
    logic [DataW-1:0]   rd_word;

    assign fetch_ready = ((state_q == StIdle) || ((state_q == StResp) && !stall))
                         && !load_en && !flush && !reset;
    assign accept       = fetch_req && fetch_ready;
    assign misaligned   = fetch_addr[OffW-1:0] != '0;
    assign out_of_range = fetch_addr > LastA;
    assign base         = fetch_addr[IdxW-1:0];

    // Faulting fetches never touch the array, so base+i cannot wrap here.
    always_comb begin
        rd_word = '0;
        if (!misaligned && !out_of_range) begin
            for (int i = 0; i < INSTR_BYTES; i++) begin
                if (BIG_ENDIAN) begin
                    rd_word[8*(INSTR_BYTES-1-i) +: 8] = mem[base + IdxW'(i)];
                end else begin
                    rd_word[8*i +: 8] = mem[base + IdxW'(i)];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        fault_d = fault_q;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (accept) begin
            fault_d = misaligned ? 2'b01 : (out_of_range ? 2'b10 : 2'b00);
            instr_d = (misaligned || out_of_range) ? '0 : rd_word;
            if (READ_LATENCY > 1) begin
                state_d = StWait;
                cnt_d   = 3'd1;
            end else begin
                state_d = StResp;
            end
        end else begin
            case (state_q)
                StWait: begin
                    if (cnt_q == LastCnt) begin
                        state_d = StResp;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                StResp: begin
                    if (!stall) begin
                        state_d = StIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            instr_q <= '0;
            fault_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    // Array contents survive reset; out-of-range loads are dropped.
    always_ff @(posedge clk) begin
        if (load_en && (load_addr < DepthA)) begin
            mem[load_addr[IdxW-1:0]] <= load_data;
        end
    end

    assign instr_valid = state_q == StResp;
    assign instruction = instr_q;
    assign fault       = fault_q;

endmodule
